// File: rtl/ap_unsi_mult_pipe_pkg.sv
// Shared types and helpers for the pipelined unsigned approximate multiplier.
package ap_mult_pkg;

  // Widest operand the library is built for.
  localparam int MAX_WIDTH = 16;

  // Per-transaction arithmetic mode.
  typedef enum logic {
    AP_MODE_EXACT  = 1'b0,
    AP_MODE_APPROX = 1'b1
  } ap_mode_e;

  // Product width for a given operand width.
  function automatic int res_w(input int width);
    return 2 * width;
  endfunction

  // Number of partial-product bits that land in product column k.
  function automatic int col_height(input int k, input int width);
    if (k < 0 || k > 2 * width - 2) return 0;
    return (k < width) ? k + 1 : 2 * width - 1 - k;
  endfunction

endpackage

// File: rtl/ap_unsi_mult_pipe_if.sv
// Operand/result stream bundle for ap_unsi_mult_pipe.
interface ap_unsi_mult_pipe_if
  import ap_mult_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          a;
  logic [WIDTH-1:0]          b;
  logic                      approx_en;
  logic                      out_valid;
  logic                      out_ready;
  logic [res_w(WIDTH)-1:0]   res;
  logic                      res_approx;
  logic [15:0]               done_cnt;

  // Producer/consumer side driving operands and accepting results.
  modport master (
    output in_valid, a, b, approx_en, out_ready,
    input  in_ready, out_valid, res, res_approx, done_cnt
  );

  // Multiplier side.
  modport slave (
    input  in_valid, a, b, approx_en, out_ready,
    output in_ready, out_valid, res, res_approx, done_cnt
  );

endinterface

// File: rtl/ap_unsi_mult_pipe_ppcom.sv
// Combinational reduction of the partial-product matrix to a sum row and a
// carry row. In approximate mode the lowest APPROX_COLS columns are replaced
// by the OR of their bits and contribute no carries.
module ap_ppcom_stage
  import ap_mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 3
) (
  input  logic [WIDTH-1:0][WIDTH-1:0] pp,        // pp[i][j] = a[j] & b[i]
  input  ap_mode_e                    mode,
  output logic [2*WIDTH-1:0]          sum_row,
  output logic [2*WIDTH-1:0]          carry_row
);

  localparam int RES_W = res_w(WIDTH);

  // Columns that are approximated when the mode asks for it.
  localparam logic [RES_W-1:0] APPROX_MASK =
    (APPROX_COLS == 0) ? '0 : ({RES_W{1'b1}} >> (RES_W - APPROX_COLS));

  // Linear 3:2 carry-save chain over shifted rows, low columns masked off and
  // refilled with their OR when approximating.
  always_comb begin
    logic [RES_W-1:0] keep_mask;
    logic [RES_W-1:0] or_low;
    logic [RES_W-1:0] s;
    logic [RES_W-1:0] c;
    logic [RES_W-1:0] r;
    logic [RES_W-1:0] s_n;
    // NOTE: every variable gets a value before any conditional path so no latch is inferred.
    keep_mask = (mode == AP_MODE_APPROX) ? ~APPROX_MASK : {RES_W{1'b1}};
    or_low    = '0;
    r         = '0;
    s_n       = '0;

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        if (i + j < APPROX_COLS) or_low[i+j] = or_low[i+j] | pp[i][j];
      end
    end
    or_low = or_low & ~keep_mask;

    // Masked columns hold only zeros, so no carry ever leaves them.
    s = RES_W'(pp[0]) & keep_mask;
    c = (RES_W'(pp[1]) << 1) & keep_mask;
    for (int i = 2; i < WIDTH; i++) begin
      r   = (RES_W'(pp[i]) << i) & keep_mask;
      s_n = s ^ c ^ r;
      c   = ((s & c) | (s & r) | (c & r)) << 1;
      s   = s_n;
    end

    sum_row   = s | or_low;
    carry_row = c;
  end

endmodule

// File: rtl/ap_unsi_mult_pipe.sv
// Three-stage valid/ready pipelined unsigned approximate multiplier:
// S1 partial products, S2 two-row compression, S3 carry-propagate add.
module ap_unsi_mult_pipe
  import ap_mult_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 3
) (
  input logic                clk,
  input logic                rst_n,
  ap_unsi_mult_pipe_if.slave bus
);

  localparam int RES_W = res_w(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0][WIDTH-1:0] pp;
    ap_mode_e                    mode;
  } stage1_t;

  typedef struct packed {
    logic [RES_W-1:0] sum_row;
    logic [RES_W-1:0] carry_row;
    ap_mode_e         mode;
  } stage2_t;

  logic             stall;
  logic             s1_valid;
  logic             s2_valid;
  logic             s3_valid;
  stage1_t          s1_d;
  stage1_t          s1_q;
  stage2_t          s2_q;
  logic [RES_W-1:0] sum_row;
  logic [RES_W-1:0] carry_row;
  logic [RES_W-1:0] res_q;
  ap_mode_e         res_mode_q;
  logic [15:0]      done_cnt_q;

  // A result held at the output freezes the whole pipe; bubbles are kept.
  assign stall        = s3_valid && !bus.out_ready;
  assign bus.in_ready = !stall;

  // Build the partial-product matrix from the incoming operands.
  always_comb begin
    s1_d      = '0;
    s1_d.mode = ap_mode_e'(bus.approx_en);
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        s1_d.pp[i][j] = bus.a[j] & bus.b[i];
      end
    end
  end

  // S1 register: partial products and mode.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (!stall) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_q <= s1_d;
    end
  end

  ap_ppcom_stage #(
    .WIDTH       (WIDTH),
    .APPROX_COLS (APPROX_COLS)
  ) u_ppcom (
    .pp        (s1_q.pp),
    .mode      (s1_q.mode),
    .sum_row   (sum_row),
    .carry_row (carry_row)
  );

  // S2 register: compressed sum/carry rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= '{sum_row: sum_row, carry_row: carry_row, mode: s1_q.mode};
    end
  end

  // S3 register: final carry-propagate add into the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid   <= 1'b0;
      res_q      <= '0;
      res_mode_q <= AP_MODE_EXACT;
    end else if (!stall) begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        res_q      <= s2_q.sum_row + s2_q.carry_row;
        res_mode_q <= s2_q.mode;
      end
    end
  end

  // Count results taken by the consumer; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt_q <= '0;
    end else if (s3_valid && bus.out_ready) begin
      done_cnt_q <= done_cnt_q + 16'd1;
    end
  end

  assign bus.out_valid  = s3_valid;
  assign bus.res        = res_q;
  assign bus.res_approx = (res_mode_q == AP_MODE_APPROX);
  assign bus.done_cnt   = done_cnt_q;

endmodule

// File: doc/ap_unsi_mult_pipe.md
Name: ap_unsi_mult_pipe

Overview:
Parametrised, pipelined unsigned approximate multiplier. It is the successor to the fixed 4x4 approximate Wallace compressor. Operand width and approximate column count are generics. The exact/approximate mode is selectable per transaction. Operands flow through a 3-stage valid/ready pipeline, so the block drops into streaming datapaths (MAC arrays, filter taps) in the approximate-multiplier library.

Parameters:
WIDTH, 8, operand width in bits (legal 2..16)
APPROX_COLS, 3, number of LSB product columns computed approximately when approx mode is on (legal 0..2*WIDTH-1; 0 = always exact)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand transaction valid
in_ready  out  1  block can accept a transaction this cycle
a  in  WIDTH  multiplicand, unsigned
b  in  WIDTH  multiplier, unsigned
approx_en  in  1  1 = approximate low columns, 0 = exact product; sampled with a/b
out_valid  out  1  res valid
out_ready  in  1  downstream accepts res
res  out  2*WIDTH  product
res_approx  out  1  approx_en value carried with this result
done_cnt  out  16  count of results accepted downstream, wraps

Behaviour:
- Reset (async assert, sync release): all stage valids = 0, out_valid = 0, res = 0, res_approx = 0, done_cnt = 0. in_ready = 1 once reset is released.
- Reset mid-operation: all in-flight transactions are discarded. No result is ever emitted for them.
- Stages:
  - S1: register the WIDTH x WIDTH partial-product matrix pp[i][j] = a[j] & b[i], plus approx_en.
  - S2: reduce the matrix to two rows (sum row, carry row) with 3:2/4:2 compression; approx columns are handled here.
  - S3: final carry-propagate add into res.
- Latency: 3 cycles from in_valid&&in_ready to out_valid when not stalled. Throughput 1 per cycle.
- Handshake: global stall = out_valid && !out_ready. Every stage register holds when stalled.
  - in_ready = !stall (combinational from out_ready).
  - Bubbles are not collapsed.
  - res and res_approx are stable while out_valid && !out_ready.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready; on a transfer out, done_cnt increments by 1, wrapping 0xFFFF -> 0.
- Arithmetic, approx_en = 0: res = a*b exactly, 2*WIDTH bits, no overflow possible.
- Arithmetic, approx_en = 1:
  - For each column k < APPROX_COLS, the contribution is (OR of all pp bits with i+j = k) << k. No carry leaves these columns.
  - Columns k >= APPROX_COLS are summed exactly, with carries propagated.
  - res = exact_high + approx_low, truncated to 2*WIDTH bits. Since approx_low <= exact_low, no overflow occurs.
  - This definition is the bit-exact golden model.
- Boundary cases:
  - APPROX_COLS = 0: approx_en has no effect on res, but is still reflected on res_approx.
  - a = 0 or b = 0: res = 0 in both modes.
  - in_valid held with out_ready = 0: at most 3 transactions are accepted, then in_ready = 0.
  - Simultaneous in/out transfer in the same cycle is legal.

Decomposition:
- Package ap_mult_pkg:
  - constant RES_W(WIDTH) = 2*WIDTH
  - function col_height(k, WIDTH) returning the number of pp bits in column k
  - mode constants AP_MODE_EXACT = 0, AP_MODE_APPROX = 1
  - typedef of the stage payload struct {pp matrix, approx}
- One sub-module ap_ppcom_stage (parametrised by WIDTH, APPROX_COLS): purely combinational matrix-to-two-row reduction with the approx column rule. Instantiated once inside S2; pipeline and handshake logic live in the top.

Test Plan:
1. WIDTH=4, APPROX_COLS=3, out_ready=1; a=15, b=15, approx_en=0 -> res=225 three cycles later, res_approx=0. Same operands with approx_en=1 -> res=215.
2. WIDTH=4, APPROX_COLS=3; a=3, b=3 -> exact mode res=9; approx mode res=7. Also a=5, b=3 -> res=15 in both modes (no column collisions).
3. Back-to-back stream of 100 random a/b pairs with random approx_en, out_ready=1 -> one result per cycle, in order, bit-matching the golden model; done_cnt=100.
4. Stall: in_valid held high, out_ready=0 for 10 cycles -> exactly 3 accepted, in_ready=0 after the fill, res held stable. Release out_ready -> the 3 results drain in order, with no loss or duplication.
5. Reset: assert rst_n=0 with 2 transactions in flight -> out_valid, res and done_cnt go to 0 immediately (async). After release, no stale result appears and in_ready=1.
6. Sweep WIDTH in {2, 8, 16} with APPROX_COLS=0: exhaustive (WIDTH=2) or random (others) operands in both modes -> res == a*b in every case.
